// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared constants for the seven-segment animation input stage:
//                button indices, channel FSM encoding and default timings.
//  Revision    : 1.0  initial release
// ============================================================================
package seg7_pkg;

    localparam int BTN_INC_ANI = 0;
    localparam int BTN_DEC_ANI = 1;
    localparam int BTN_INC_SPD = 2;
    localparam int BTN_DEC_SPD = 3;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    // All default timings derive from the 10 MHz system clock.
    localparam int CLK_FREQ_HZ           = 10_000_000;
    localparam int DEBOUNCE_DEFAULT      = CLK_FREQ_HZ / 1000;
    localparam int REPEAT_DELAY_DEFAULT  = CLK_FREQ_HZ / 2;
    localparam int REPEAT_PERIOD_DEFAULT = CLK_FREQ_HZ / 5;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_channel.sv
`default_nettype none
// ============================================================================
//  Module      : btn_channel
//  Description : One button: 2-FF synchronizer, counter debouncer and a
//                press/hold/repeat FSM producing registered pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module btn_channel
    import seg7_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter bit REPEAT_EN       = 1'b1,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int c_DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int c_RP_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD));

    localparam logic [c_DB_W-1:0] c_DB_LAST     = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_RP_W-1:0] c_DELAY_LAST  = c_RP_W'(REPEAT_DELAY - 1);
    localparam logic [c_RP_W-1:0] c_PERIOD_LAST = c_RP_W'(REPEAT_PERIOD - 1);

    logic [1:0]        r_sync_ff;
    logic              r_stable;
    logic [c_DB_W-1:0] r_db_cnt;
    logic [1:0]        r_state;
    logic [c_RP_W-1:0] r_rcnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_ff <= 2'b00;
        end else begin
            r_sync_ff <= {r_sync_ff[0], i_raw};
        end
    end

    // Any return to the stable value restarts the qualification window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stable <= 1'b0;
            r_db_cnt <= '0;
        end else if (r_sync_ff[1] == r_stable) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt == c_DB_LAST) begin
            r_stable <= r_sync_ff[1];
            r_db_cnt <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_rcnt    <= '0;
            o_level   <= 1'b0;
            o_press   <= 1'b0;
            o_release <= 1'b0;
        end else begin
            o_level   <= r_stable;
            o_press   <= 1'b0;
            o_release <= 1'b0;
            // Release is checked first so it wins over a coincident repeat tick.
            if (!r_stable && (r_state != ST_IDLE)) begin
                o_release <= 1'b1;
                r_rcnt    <= '0;
                r_state   <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (r_stable) begin
                            o_press <= 1'b1;
                            r_rcnt  <= '0;
                            r_state <= ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        if (r_rcnt == c_DELAY_LAST) begin
                            if (REPEAT_EN) begin
                                o_press <= 1'b1;
                                r_rcnt  <= '0;
                                r_state <= ST_REPEAT;
                            end
                        end else begin
                            r_rcnt <= r_rcnt + 1'b1;
                        end
                    end
                    ST_REPEAT: begin
                        if (r_rcnt == c_PERIOD_LAST) begin
                            o_press <= 1'b1;
                            r_rcnt  <= '0;
                        end else begin
                            r_rcnt <= r_rcnt + 1'b1;
                        end
                    end
                    default: begin
                        r_rcnt  <= '0;
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : button_conditioner
//  Description : NUM_BTN independent button channels; the wrapper only
//                concatenates the per-channel outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module button_conditioner
    import seg7_pkg::*;
#(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter bit REPEAT_EN       = 1'b1,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release
);

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_chan
            btn_channel #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .REPEAT_EN       (REPEAT_EN),
                .REPEAT_DELAY    (REPEAT_DELAY),
                .REPEAT_PERIOD   (REPEAT_PERIOD)
            ) u_chan (
                .clk       (clk),
                .rst_n     (rst_n),
                .i_raw     (btn_raw[gi]),
                .o_level   (btn_level[gi]),
                .o_press   (btn_press[gi]),
                .o_release (btn_release[gi])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_conditioner
//  Description : Directed self-checking bench for button_conditioner.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_button_conditioner;
    import seg7_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [3:0] btn_raw;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_release;
    logic [3:0] nr_raw;
    logic [3:0] nr_level;
    logic [3:0] nr_press;
    logic [3:0] nr_release;

    int r_tests;
    int r_fails;

    button_conditioner #(
        .NUM_BTN(4), .DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b1),
        .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
    );

    button_conditioner #(
        .NUM_BTN(4), .DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b0),
        .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
    ) dut_norep (
        .clk(clk), .rst_n(rst_n), .btn_raw(nr_raw),
        .btn_level(nr_level), .btn_press(nr_press), .btn_release(nr_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        r_tests++;
        if (got !== exp) begin
            r_fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic sample_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        int press_cnt;
        int rel_cnt;
        int press_at;
        r_tests = 0;
        r_fails = 0;
        rst_n   = 1'b0;
        btn_raw = 4'b0000;
        nr_raw  = 4'b0000;

        // Reset state
        repeat (3) sample_edge();
        check("rst_level", {28'd0, btn_level}, 32'd0);
        check("rst_press", {28'd0, btn_press}, 32'd0);
        check("rst_release", {28'd0, btn_release}, 32'd0);
        check("rst_nr_outs", {20'd0, nr_level, nr_press, nr_release}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);

        // 1: single press latency and level alignment
        @(negedge clk);
        btn_raw[BTN_INC_ANI] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            sample_edge();
            check($sformatf("t1_press_e%0d", k), {28'd0, btn_press}, (k == 7) ? 32'd1 : 32'd0);
            check($sformatf("t1_level_e%0d", k), {28'd0, btn_level}, (k >= 7) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        btn_raw[BTN_INC_ANI] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            sample_edge();
            check($sformatf("t1_rel_e%0d", k), {28'd0, btn_release}, (k == 7) ? 32'd1 : 32'd0);
            check($sformatf("t1_relpress_e%0d", k), {28'd0, btn_press}, 32'd0);
        end
        idle(4);

        // 2: bouncing input never qualifies
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            btn_raw[BTN_DEC_ANI] = (i < 40) && (((i / 2) % 2) == 0);
            sample_edge();
            check("t2_bit1_quiet", {29'd0, btn_level[1], btn_press[1], btn_release[1]}, 32'd0);
        end

        // 3: auto-repeat schedule, release wins over coincident tick
        @(negedge clk);
        btn_raw[BTN_INC_SPD] = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            sample_edge();
            check($sformatf("t3_press_e%0d", k), {31'd0, btn_press[2]},
                  (k == 7 || k == 27 || k == 35 || k == 43 || k == 51 || k == 59) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        btn_raw[BTN_INC_SPD] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            sample_edge();
            check($sformatf("t3_rel_e%0d", k), {31'd0, btn_release[2]}, (k == 7) ? 32'd1 : 32'd0);
            check($sformatf("t3_nopress_e%0d", k), {31'd0, btn_press[2]}, 32'd0);
            check($sformatf("t3_level_e%0d", k), {31'd0, btn_level[2]}, (k < 7) ? 32'd1 : 32'd0);
        end
        idle(4);

        // 4: simultaneous presses, no masking
        @(negedge clk);
        btn_raw = 4'b1111;
        for (int k = 1; k <= 9; k++) begin
            sample_edge();
            check($sformatf("t4_all_e%0d", k), {28'd0, btn_press}, (k == 7) ? 32'hF : 32'd0);
        end
        @(negedge clk);
        btn_raw = 4'b0000;
        for (int k = 1; k <= 9; k++) begin
            sample_edge();
            check($sformatf("t4_allrel_e%0d", k), {28'd0, btn_release}, (k == 7) ? 32'hF : 32'd0);
        end
        idle(4);
        @(negedge clk);
        btn_raw = 4'b0011;
        for (int k = 1; k <= 9; k++) begin
            sample_edge();
            check($sformatf("t4_pair_e%0d", k), {28'd0, btn_press}, (k == 7) ? 32'h3 : 32'd0);
        end
        @(negedge clk);
        btn_raw = 4'b0000;
        idle(12);

        // 5: asynchronous reset while repeating, then re-press after release
        @(negedge clk);
        btn_raw[BTN_INC_ANI] = 1'b1;
        for (int k = 1; k <= 35; k++) begin
            sample_edge();
        end
        check("t5_repeat_tick", {28'd0, btn_press}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_clear", {20'd0, btn_level, btn_press, btn_release}, 32'd0);
        for (int k = 1; k <= 3; k++) begin
            sample_edge();
            check($sformatf("t5_in_rst_%0d", k), {20'd0, btn_level, btn_press, btn_release}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            sample_edge();
            check($sformatf("t5_press_e%0d", k), {28'd0, btn_press}, (k == 7) ? 32'd1 : 32'd0);
            check($sformatf("t5_norel_e%0d", k), {28'd0, btn_release}, 32'd0);
        end
        @(negedge clk);
        btn_raw = 4'b0000;
        idle(12);

        // 6: repeat disabled, one press and one release only
        press_cnt = 0;
        rel_cnt   = 0;
        press_at  = -1;
        @(negedge clk);
        nr_raw[BTN_DEC_SPD] = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            sample_edge();
            if (nr_press[3]) begin
                press_cnt++;
                press_at = k;
            end
            if (nr_release[3]) rel_cnt++;
        end
        check("t6_press_cnt", press_cnt, 1);
        check("t6_press_edge", press_at, 7);
        check("t6_rel_while_held", rel_cnt, 0);
        @(negedge clk);
        nr_raw[BTN_DEC_SPD] = 1'b0;
        press_cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            sample_edge();
            if (nr_press[3]) press_cnt++;
            if (nr_release[3]) rel_cnt++;
        end
        check("t6_rel_cnt", rel_cnt, 1);
        check("t6_press_after", press_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", r_tests, r_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish (tests %0d)", r_tests);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Upstream input stage for the seven-segment animation top level. It turns the four raw push-button inputs into clean, clock-domain-safe signals:
- increment animation (bit 0)
- decrement animation (bit 1)
- increment speed (bit 2)
- decrement speed (bit 3)

Per button it provides a 2-FF synchronizer, a counter-based debouncer, and single-cycle press/release pulses with optional auto-repeat. The top level consumes btn_press as its one-cycle "step" strobes, replacing its combinational debounce logic.

Parameters:
- NUM_BTN, 4, number of independent button channels.
- DEBOUNCE_CYCLES, 10000, cycles the synchronized input must differ from the stable level before the level flips (1 ms at 10 MHz); must be >= 2.
- REPEAT_EN, 1, 1 = held button generates repeat pulses; 0 = press pulse only.
- REPEAT_DELAY, 5000000, cycles from the press pulse to the first repeat pulse (0.5 s); must be >= 2.
- REPEAT_PERIOD, 2000000, cycles between subsequent repeat pulses (0.2 s); must be >= 2.

Ports:
- clk, input, 1, system clock (10 MHz).
- rst_n, input, 1, asynchronous active-low reset.
- btn_raw, input, NUM_BTN, asynchronous button levels, active high (ui_in[3:0]).
- btn_level, output, NUM_BTN, debounced stable level per button.
- btn_press, output, NUM_BTN, one-cycle pulse on debounced rising edge and on each auto-repeat tick.
- btn_release, output, NUM_BTN, one-cycle pulse on debounced falling edge.

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n). All flops clear on rst_n low, independent of clk.
- Reset values: btn_level=0, btn_press=0, btn_release=0. Synchronizers, debounce counters and repeat counters are 0; all channels are in IDLE.
- Synchronizer: 2 flops per bit, reset 0. sync = second flop.
- Debounce, per channel; counter width $clog2(DEBOUNCE_CYCLES):
  - If sync == stable: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= sync and cnt <= 0.
  - Else: cnt <= cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles (post-sync) never changes stable. Any bounce back to the stable value restarts the count from 0.
- Latency: btn_raw rises and is held. Counting edge 1 as the first edge that samples it high:
  - stable goes high at edge DEBOUNCE_CYCLES+2.
  - btn_press is high for exactly the cycle after edge DEBOUNCE_CYCLES+3.
  - Falling edge is symmetric, with btn_release in place of btn_press.
- btn_level = stable, registered once more so it aligns with the btn_press/btn_release cycle.
- Per-channel FSM (repeat counter width $clog2(max(REPEAT_DELAY, REPEAT_PERIOD))):
  - IDLE: on stable rising → assert press, rcnt <= 0, go to HOLD.
  - HOLD: rcnt increments. When rcnt == REPEAT_DELAY-1 and REPEAT_EN → assert press, rcnt <= 0, go to REPEAT. If REPEAT_EN=0, stay in HOLD with rcnt saturated.
  - REPEAT: rcnt increments. When rcnt == REPEAT_PERIOD-1 → assert press, rcnt <= 0.
  - Any state: stable falling → assert release, rcnt <= 0, go to IDLE. A release takes priority over a coincident repeat tick: that cycle gives a release pulse and no press pulse.
- Channels are fully independent. Simultaneous presses on several bits produce simultaneous pulses; arbitration belongs to the consumer.
- btn_press and btn_release are never both high on the same bit in the same cycle.
- Reset mid-operation: all pulses stop immediately, with none emitted during or on release of reset. A button still held at reset release produces a normal press after the full debounce latency.
- No combinational path from btn_raw to any output.

Decomposition:
- Shared package seg7_pkg:
  - Button index constants BTN_INC_ANI=0, BTN_DEC_ANI=1, BTN_INC_SPD=2, BTN_DEC_SPD=3.
  - FSM state encoding IDLE/HOLD/REPEAT as a 2-bit localparam set.
  - Default timing constants, with the 10 MHz clock frequency as the base.
- One sub-module, btn_channel: single-bit synchronizer + debouncer + FSM, instantiated NUM_BTN times via generate. The top wrapper only concatenates the channel outputs.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, REPEAT_EN=1.
1. btn_raw[0] held high from edge 1 → btn_press[0] high only in the cycle after edge 7; btn_level[0]=1 from that cycle onward; other bits stay 0.
2. btn_raw[1] toggles every 2 cycles for 40 cycles, then stays 0 → btn_level[1] and all pulses on bit 1 stay 0 throughout.
3. btn_raw[2] held 60 cycles → press at edge 7, then repeats at edges 27, 35, 43, 51, 59. Release pulse 7 cycles after the input falls, with no further presses after it.
4. btn_raw[3:0]=4'b1111 simultaneously → btn_press=4'b1111 in the same single cycle. Raising only btn_raw[0] and btn_raw[1] → both pulse in the same cycle, no masking.
5. rst_n low for 3 cycles while btn_raw[0] has been held long enough to be in REPEAT → outputs 0 immediately (asynchronous). After release with the button still held, a single press arrives 7 edges later.
6. REPEAT_EN=0, button held 100 cycles → exactly one press pulse, then exactly one release pulse after the input drops.
